// File: rtl/serial_adder_seq.sv
// Bit-serial adder controller around one external full-adder stage.
// Operands go out LSB-first, one bit per clock; the sum shifts in MSB-first and is latched on completion.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;

  assign w_last = (r_count == LAST_BIT);

  // New sum bit enters at the MSB; written as a shift-and-or so WIDTH=1 needs no special case.
  assign w_sum_next = (r_sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        w_shift = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the datapath registers are reset too, because an abort must leave fa_* and results at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= a_in;
      r_b_sh  <= b_in;
      r_carry <= cin_in;
      r_count <= '0;
    end else if (w_shift) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_next;
      r_carry  <= fa_cout;
      r_count  <= r_count + 1'b1;
      if (w_last) begin
        r_sum_out  <= w_sum_next;
        r_cout_out <= fa_cout;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign fa_a     = busy & r_a_sh[0];
  assign fa_b     = busy & r_b_sh[0];
  assign fa_cin   = busy & r_carry;
  assign sum_out  = r_sum_out;
  assign cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: an 8-bit and a 1-bit instance, each closed through a
// behavioural full-adder stage, exercised with directed vectors.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, cin8, fa8_a, fa8_b, fa8_cin, fa8_s, fa8_cout, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, fa1_a, fa1_b, fa1_cin, fa1_s, fa1_cout, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  // External full-adder stages.
  assign fa8_s    = fa8_a ^ fa8_b ^ fa8_cin;
  assign fa8_cout = (fa8_a & fa8_b) | (fa8_cin & (fa8_a ^ fa8_b));
  assign fa1_s    = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_cout = (fa1_a & fa1_b) | (fa1_cin & (fa1_a ^ fa1_b));

  serial_adder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_cin(fa8_cin), .fa_s(fa8_s), .fa_cout(fa8_cout),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin), .fa_s(fa1_s), .fa_cout(fa1_cout),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // One 8-bit add with a one-cycle start pulse; observes 12 cycles (index i = sample after edge Ei, E0 = start edge).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int busy_cnt, output int done_idx, output int done_cnt, output int cin_ones);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = 8'($urandom); cin8 = ~c;
    busy_cnt = 0; done_idx = -1; done_cnt = 0; cin_ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (busy8) begin
        busy_cnt++;
        if (fa8_cin) cin_ones++;
      end
      if (done8) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy8, done8, fa8_a, fa8_b, fa8_cin, cout8, sum8} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_w8: got %b expected all zero", {busy8, done8, fa8_a, fa8_b, fa8_cin, cout8, sum8});
    end
    n_tests++;
    if ({busy1, done1, fa1_a, fa1_b, fa1_cin, cout1, sum1} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_w1: got %b expected all zero", {busy1, done1, fa1_a, fa1_b, fa1_cin, cout1, sum1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/done %b expected 00", {busy8, done8});
    end
  endtask

  task automatic test_zero();
    int bc, di, dc, co;
    run8(8'h00, 8'h00, 1'b0, bc, di, dc, co);
    n_tests++;
    if ({cout8, sum8} !== 9'h000) begin
      n_fail++;
      $display("FAIL zero_sum: got %h expected 000", {cout8, sum8});
    end
    n_tests++;
    if (bc !== 8) begin
      n_fail++;
      $display("FAIL zero_busy_cycles: got %0d expected 8", bc);
    end
    n_tests++;
    if (di !== 8 || dc !== 1) begin
      n_fail++;
      $display("FAIL zero_done_timing: got edge %0d count %0d expected edge 8 count 1", di, dc);
    end
  endtask

  task automatic test_carry();
    int bc, di, dc, co;
    run8(8'hFF, 8'h01, 1'b0, bc, di, dc, co);
    n_tests++;
    if ({cout8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL ff_plus_01: got %h expected 100", {cout8, sum8});
    end
    run8(8'hA5, 8'h5A, 1'b1, bc, di, dc, co);
    n_tests++;
    if ({cout8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL a5_5a_cin: got %h expected 100", {cout8, sum8});
    end
    n_tests++;
    if (co !== 8) begin
      n_fail++;
      $display("FAIL a5_5a_fa_cin: got %0d run cycles with fa_cin=1 expected 8", co);
    end
    run8(8'h3C, 8'h5A, 1'b0, bc, di, dc, co);
    n_tests++;
    if ({cout8, sum8} !== 9'h096 || di !== 8) begin
      n_fail++;
      $display("FAIL 3c_plus_5a: got %h at edge %0d expected 096 at edge 8", {cout8, sum8}, di);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 8) begin
        n_tests++;
        if ({done8, busy8, cout8, sum8} !== 11'b10_0_0100_0110) begin
          n_fail++;
          $display("FAIL b2b_first: got done/busy/res %b expected 10/046", {done8, busy8, cout8, sum8});
        end
      end
      if (i == 9) begin
        n_tests++;
        if ({busy8, done8} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_no_idle: got busy/done %b expected 10", {busy8, done8});
        end
        start8 = 1'b0;
      end
      if (i == 12) begin
        n_tests++;
        if ({cout8, sum8} !== 9'h046) begin
          n_fail++;
          $display("FAIL b2b_sum_held: got %h expected 046", {cout8, sum8});
        end
        start8 = 1'b1;
      end
      if (i == 13) start8 = 1'b0;
      if (i == 17) begin
        n_tests++;
        if ({done8, cout8, sum8} !== 10'h300) begin
          n_fail++;
          $display("FAIL b2b_second: got done/res %h expected 300", {done8, cout8, sum8});
        end
      end
      if (i == 18) begin
        n_tests++;
        if ({busy8, done8} !== 2'b00) begin
          n_fail++;
          $display("FAIL b2b_idle_after: got busy/done %b expected 00", {busy8, done8});
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, di, dc, co;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 3; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({busy8, done8, fa8_a, fa8_b, fa8_cin, cout8, sum8} !== 14'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %b expected all zero", {busy8, done8, fa8_a, fa8_b, fa8_cin, cout8, sum8});
    end
    @(negedge clk);
    n_tests++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrun_idle: got busy/done %b expected 00", {busy8, done8});
    end
    run8(8'h0F, 8'h01, 1'b0, bc, di, dc, co);
    n_tests++;
    if ({cout8, sum8} !== 9'h010 || di !== 8) begin
      n_fail++;
      $display("FAIL post_reset_add: got %h at edge %0d expected 010 at edge 8", {cout8, sum8}, di);
    end
  endtask

  task automatic test_width1();
    // Full-adder truth table indexed by {a,b,cin}: value is {cout,s}.
    logic [1:0] tt [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      @(negedge clk);
      n_tests++;
      if ({done1, busy1} !== 2'b10) begin
        n_fail++;
        $display("FAIL w1_done_%0d: got done/busy %b expected 10", k, {done1, busy1});
      end
      n_tests++;
      if ({cout1, sum1} !== tt[k]) begin
        n_fail++;
        $display("FAIL w1_sum_%0d: got %b expected %b", k, {cout1, sum1}, tt[k]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
Bit-serial multi-bit adder controller that sits directly around one full-adder stage. It serialises two WIDTH-bit operands LSB-first onto the stage's a/b/cin inputs, one bit per clock. It consumes the stage's s/cout each cycle, holding the carry in a flop and shifting sum bits into a result register. The full-adder stage is instantiated externally and wired to the fa_* ports, so this block drives it and consumes its outputs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request to begin an add; sampled only in IDLE or DONE.
a_in  input  WIDTH  operand A; captured on the accepted start edge.
b_in  input  WIDTH  operand B; captured on the accepted start edge.
cin_in  input  1  initial carry-in; captured on the accepted start edge.
fa_a  output  1  to stage input a; A shift register bit 0 during RUN, else 0.
fa_b  output  1  to stage input b; B shift register bit 0 during RUN, else 0.
fa_cin  output  1  to stage input cin; carry flop during RUN, else 0.
fa_s  input  1  from stage sum output.
fa_cout  input  1  from stage carry output.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result valid.
sum_out  output  WIDTH  registered sum; held until the next accepted start.
cout_out  output  1  registered final carry; held with sum_out.

Behaviour:
- One clock. Reset is synchronous and active-low, named rst_n; clock is clk.
- Reset at any time, including mid-RUN, aborts the current operation.
  - State goes to IDLE.
  - busy, done, fa_*, sum_out, cout_out, bit counter, carry flop and shift registers all go to 0.
- The fa_* outputs are combinational from registered state. fa_s/fa_cout are treated as a same-cycle combinational return.
- States:
  - IDLE: busy=0, done=0. If start=1, load a_in/b_in into the shift registers, load cin_in into the carry flop, set count=0, go to RUN.
  - RUN: busy=1. Each edge does the following:
    - Shift the A and B registers right by 1.
    - Shift the sum register right, inserting fa_s at bit WIDTH-1.
    - Update carry <= fa_cout and count <= count+1.
    - When count==WIDTH-1 at the edge, go to DONE. Copy the completed sum to sum_out and fa_cout to cout_out on that same edge.
    - start is ignored in RUN.
  - DONE: done=1, busy=0, for exactly one cycle.
    - If start=1, behave as IDLE accepting start (load, go to RUN); back-to-back operation is legal.
    - Otherwise go to IDLE.
- Latency: if start is accepted at edge E0, bits are processed at edges E1..E_WIDTH. done is high during the cycle after E_WIDTH, and sum_out/cout_out are valid from that cycle onward.
- Throughput: one add per WIDTH+1 cycles when start is held high.
- sum_out is updated only on the RUN-to-DONE edge. It is not updated during RUN and is not cleared on start.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin_in, unsigned, WIDTH+1 bits, no saturation. Carry out of bit WIDTH-1 appears only on cout_out.
- Counter width is clog2(WIDTH+1). WIDTH=1 must work: RUN lasts one edge.
- Operand inputs may change freely after the start edge without affecting the result.

Test Plan:
- WIDTH=1, exhaustively drive all 8 {a,b,cin} combinations via start. Required: {cout_out,sum_out} matches the full-adder truth table, and done pulses 2 edges after each start.
- WIDTH=8, a=0x00, b=0x00, cin=0. Required: sum_out=0x00, cout_out=0, busy high for exactly 8 cycles, done high for exactly 1 cycle 9 edges after start.
- WIDTH=8, a=0xFF, b=0x01, cin=0. Required: sum_out=0x00, cout_out=1. Also a=0xA5, b=0x5A, cin=1. Required: sum_out=0x00, cout_out=1, with fa_cin=1 on every RUN cycle.
- WIDTH=8, start held high continuously with new operands (0x12+0x34, then 0x80+0x80). Required: sum_out=0x46/cout 0, then 0x00/cout 1. The second start is accepted in DONE with no idle cycle, and start pulses during RUN are ignored.
- WIDTH=8, rst_n low for one edge at RUN bit 4. Required: next cycle all outputs are 0 and the state is IDLE. A subsequent 0x0F+0x01 gives 0x10/cout 0, with no stale carry.
